// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//
// Multi-cycle multiply/divide engine that sits in the EX stage right behind
// the ID/EX pipeline register. It takes the RD1/RD2 operands of
// MULT/MULTU/DIV/DIVU and produces the 64-bit HI/LO result for the HI/LO
// write-back path. While an operation is in flight, it holds the front of
// the pipeline with a combinational stall.
//
// Ports:
//   clk     in   1   clock, rising edge
//   rst     in   1   asynchronous active-high reset
//   flush   in   1   synchronous abort of the operation in flight
//   start   in   1   EX holds a mul/div instruction (sampled only in IDLE)
//   op      in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val  in  32   operand A (multiplicand / dividend)
//   rt_val  in  32   operand B (multiplier / divisor)
//   stall   out  1   combinational hold for the IF/ID/EX registers
//   busy    out  1   registered, high while in MUL or DIV
//   done    out  1   registered one-cycle pulse, hi/lo valid
//   hi      out 32   product[63:32] or remainder
//   lo      out 32   product[31:0] or quotient
//
// Parameters:
//   MUL_CYCLES  cycles spent in MUL (minimum 1)
//   DIV_ITER    restoring-division iterations; must equal operand width (32)
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_ITER   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CNT = (MUL_CYCLES > DIV_ITER) ? MUL_CYCLES : DIV_ITER;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0] count;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;
    logic [31:0]      rem_q;
    logic [31:0]      quo_q;
    logic             neg_q;
    logic             neg_r;

    // Operand conditioning for the start edge. Signed ops work on
    // magnitudes; the result signs are remembered separately and applied
    // once at the end. 0x80000000 keeps its bit pattern, which is its
    // correct unsigned magnitude.
    logic        accept;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    always_comb begin
        accept = (state == S_IDLE) && start && !flush;
        sign_a = !op[0] && rs_val[31];
        sign_b = !op[0] && rt_val[31];
        abs_a  = sign_a ? (~rs_val + 32'd1) : rs_val;
        abs_b  = sign_b ? (~rt_val + 32'd1) : rt_val;
    end

    // One restoring-division step. The partial remainder always stays below
    // the divisor, so the shifted value fits in 33 bits. Bit 32 of the trial
    // difference acts as the borrow.
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        step_ok;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] rem_fix;
    logic [31:0] quo_fix;

    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        diff     = shifted - {1'b0, b_mag};
        step_ok  = !diff[32];
        rem_next = step_ok ? diff[31:0] : shifted[31:0];
        quo_next = {quo_q[30:0], step_ok};
        // With a zero divisor, the quotient saturates to all ones and is
        // reported unchanged. The remainder fixup restores the original
        // dividend.
        quo_fix  = (neg_q && (b_mag != 32'd0)) ? (~quo_next + 32'd1) : quo_next;
        rem_fix  = neg_r ? (~rem_next + 32'd1) : rem_next;
    end

    // The magnitude product is formed from the latched operands and
    // negated when exactly one signed input was negative.
    logic [63:0] prod_mag;
    logic [63:0] prod;

    always_comb begin
        prod_mag = 64'(a_mag) * 64'(b_mag);
        prod     = neg_q ? (~prod_mag + 64'd1) : prod_mag;
    end

    logic last;
    assign last = (count == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A flush always returns to IDLE, and it wins over
    // start in the same cycle. DONE lasts exactly one cycle.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    next_state = S_IDLE;
                end else if (last) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Output logic. Stall is dropped in DONE so the instruction leaves EX
    // on the edge that ends DONE. A follower's start is only seen in IDLE.
    always_comb begin
        stall = (state == S_MUL) || (state == S_DIV) || accept;
    end

    // Datapath, counter and registered status flags. Operands are captured
    // only on the accepting edge, so later changes on rs_val/rt_val and
    // starts during MUL/DIV have no effect. hi/lo are written only on the
    // edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            a_mag <= '0;
            b_mag <= '0;
            rem_q <= '0;
            quo_q <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (next_state == S_MUL) || (next_state == S_DIV);
            done <= (next_state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_mag <= abs_a;
                        b_mag <= abs_b;
                        neg_q <= sign_a ^ sign_b;
                        neg_r <= sign_a;
                        rem_q <= '0;
                        quo_q <= abs_a;
                        count <= op[1] ? CNT_W'(DIV_ITER - 1) : CNT_W'(MUL_CYCLES - 1);
                    end
                end
                S_MUL: begin
                    if (!flush) begin
                        if (last) begin
                            hi <= prod[63:32];
                            lo <= prod[31:0];
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    if (!flush) begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        if (last) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
//
// Directed test bench for ex_muldiv_unit. A cycle-level reference model
// computes every result with plain 64-bit arithmetic when an operation is
// accepted. One compare process checks stall/busy/done/hi/lo against that
// model on every falling edge. Hand-computed literal values pin the model
// on each directed vector.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;

    localparam int MUL_CYCLES = 3;
    localparam int DIV_LAT    = 32;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests  = 0;
    int errors = 0;

    ex_muldiv_unit #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_ITER  (32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .start (start),
        .op    (op),
        .rs_val(rs_val),
        .rt_val(rt_val),
        .stall (stall),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one value and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain arithmetic: the product is returned as
    // {hi, lo}, and a division as {remainder, quotient}.
    function automatic logic [63:0] modelResult(input logic [1:0] o, input logic [31:0] a,
                                                input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          sq;
        longint          sr;
        longint unsigned uq;
        longint unsigned ur;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        res = '0;
        case (o)
            2'b00: res = sa * sb;
            2'b01: res = ua * ub;
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    sq  = sa / sb;
                    sr  = sa % sb;
                    res = {sr[31:0], sq[31:0]};
                end else begin
                    uq  = ua / ub;
                    ur  = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Model state: 0 idle, 1 busy, 2 done.
    int          m_phase;
    int          m_left;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_left  = 0;
            m_hi    = '0;
            m_lo    = '0;
            m_pend  = '0;
        end else begin
            case (m_phase)
                0: begin
                    if (start && !flush) begin
                        m_pend  = modelResult(op, rs_val, rt_val);
                        m_left  = op[1] ? DIV_LAT : MUL_CYCLES;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (flush) begin
                        m_phase = 0;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = 2;
                            m_hi    = m_pend[63:32];
                            m_lo    = m_pend[31:0];
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Checks every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        logic exp_stall;
        exp_stall = (m_phase == 1) || ((m_phase == 0) && start && !flush);
        checkOutput("stall", 32'(stall), 32'(exp_stall));
        checkOutput("busy",  32'(busy),  32'(m_phase == 1));
        checkOutput("done",  32'(done),  32'(m_phase == 2));
        checkOutput("hi",    hi,         m_hi);
        checkOutput("lo",    lo,         m_lo);
    end

    // Presents an instruction to EX shortly after a rising edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #2;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
    endtask

    // Waits for done with a bounded cycle budget. It counts the falling
    // edges seen before done is observed and then retires the instruction.
    task automatic waitDone(input int budget, output int lat);
        lat = 0;
        while (lat <= budget) begin
            @(negedge clk);
            if (done) break;
            lat++;
        end
        if (!done) begin
            tests++;
            errors++;
            $display("[TB] FAIL timeout: done not seen within %0d cycles", budget);
        end
        #1;
        start = 1'b0;
    endtask

    int lat;

    initial begin
        rst    = 1'b1;
        flush  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = '0;
        rt_val = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        #1;
        rst = 1'b0;

        // MULT -2 * 3, with done four cycles after start
        applyStimulus(2'b00, 32'hFFFF_FFFE, 32'd3);
        waitDone(10, lat);
        checkOutput("mult_lat", lat, 32'd4);
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU max*max; operands and start change while busy
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk);
        #2;
        rs_val = 32'h0000_1234;
        rt_val = 32'h0000_5678;
        waitDone(10, lat);
        checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
        checkOutput("multu_lo", lo, 32'h0000_0001);
        @(negedge clk);
        checkOutput("multu_done_pulse", 32'(done), 32'd0);

        // DIV -7 / 2
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2);
        waitDone(40, lat);
        checkOutput("div_lat", lat, 32'd33);
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU 100 / 7
        applyStimulus(2'b11, 32'd100, 32'd7);
        waitDone(40, lat);
        checkOutput("divu_lo", lo, 32'd14);
        checkOutput("divu_hi", hi, 32'd2);

        // DIVU by zero
        applyStimulus(2'b11, 32'h1234_5678, 32'd0);
        waitDone(40, lat);
        checkOutput("div0_lo", lo, 32'hFFFF_FFFF);
        checkOutput("div0_hi", hi, 32'h1234_5678);

        // DIV most-negative / -1
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(40, lat);
        checkOutput("divovf_lo", lo, 32'h8000_0000);
        checkOutput("divovf_hi", hi, 32'd0);

        // Flush on iteration 10, then an immediate new start
        applyStimulus(2'b10, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #2;
        flush = 1'b1;
        @(posedge clk);
        #2;
        flush  = 1'b0;
        op     = 2'b11;
        rs_val = 32'd100;
        rt_val = 32'd7;
        @(negedge clk);
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_done", 32'(done), 32'd0);
        checkOutput("flush_hi", hi, 32'd0);
        checkOutput("flush_lo", lo, 32'h8000_0000);
        checkOutput("flush_restart_stall", 32'(stall), 32'd1);
        waitDone(40, lat);
        checkOutput("flush_restart_lat", lat, 32'd32);
        checkOutput("flush_restart_lo", lo, 32'd14);
        checkOutput("flush_restart_hi", hi, 32'd2);

        // Asynchronous reset in the middle of a divide
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(posedge clk);
        #3;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_done", 32'(done), 32'd0);
        checkOutput("arst_hi", hi, 32'd0);
        checkOutput("arst_lo", lo, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;

        // MULTU 5 * 6 after reset
        applyStimulus(2'b01, 32'd5, 32'd6);
        waitDone(10, lat);
        checkOutput("post_rst_lat", lat, 32'd4);
        checkOutput("post_rst_lo", lo, 32'd30);
        checkOutput("post_rst_hi", hi, 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
